// File: rtl/clock_display.sv
// Six-digit multiplexed 7-segment driver for hh.mm.ss with frame-aligned snapshots.
// Optional field blinking during set mode is built when DISPLAY_BLINK_EN is defined.
module clock_display #(
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 50
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [5:0] i_count_h,
   input  logic [5:0] i_count_m,
   input  logic [5:0] i_count_s,
   input  logic       i_set,
   input  logic       i_hour,
   input  logic       i_min,
   input  logic       i_sec,
   output logic [7:0] o_seg,
   output logic [5:0] o_com
);

   localparam int SW = $clog2(SCAN_DIV);

   logic [SW-1:0] scan_q, scan_d;
   logic [2:0]    idx_q, idx_d;
   logic [5:0]    snap_h_q, snap_h_d;
   logic [5:0]    snap_m_q, snap_m_d;
   logic [5:0]    snap_s_q, snap_s_d;
   logic [7:0]    seg_q, seg_d;
   logic [5:0]    com_q, com_d;
   logic          scan_tick, frame_tick;
   logic [5:0]    field_val;
   logic [7:0]    bcd;
   logic [3:0]    digit;
   logic          blank;

   // Binary to two BCD digits by compare chain; 60..63 yield tens digit 6.
   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [3:0] t;
      logic [3:0] r;
      if (v >= 6'd60)      begin t = 4'd6; r = 4'(v - 6'd60); end
      else if (v >= 6'd50) begin t = 4'd5; r = 4'(v - 6'd50); end
      else if (v >= 6'd40) begin t = 4'd4; r = 4'(v - 6'd40); end
      else if (v >= 6'd30) begin t = 4'd3; r = 4'(v - 6'd30); end
      else if (v >= 6'd20) begin t = 4'd2; r = 4'(v - 6'd20); end
      else if (v >= 6'd10) begin t = 4'd1; r = 4'(v - 6'd10); end
      else                 begin t = 4'd0; r = v[3:0];       end
      return {t, r};
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   assign scan_tick  = (scan_q == SW'(SCAN_DIV - 1));
   assign frame_tick = scan_tick && (idx_q == 3'd5);

   always_comb begin
      scan_d   = scan_tick ? '0 : scan_q + 1'b1;
      idx_d    = idx_q;
      snap_h_d = snap_h_q;
      snap_m_d = snap_m_q;
      snap_s_d = snap_s_q;
      if (scan_tick)
         idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      // Snapshot only at the frame boundary so one frame never mixes two times.
      if (frame_tick) begin
         snap_h_d = i_count_h;
         snap_m_d = i_count_m;
         snap_s_d = i_count_s;
      end
   end

`ifdef DISPLAY_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV + 1);

   logic [BW-1:0] blink_q, blink_d;
   logic          phase_q, phase_d;
   logic          field_sel;

   always_comb begin
      blink_d = blink_q;
      phase_d = phase_q;
      if (frame_tick) begin
         if (blink_q == BW'(BLINK_DIV - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
         end else begin
            blink_d = blink_q + 1'b1;
         end
      end
   end

   always_comb begin
      case (idx_q[2:1])
         2'd0:    field_sel = i_hour;
         2'd1:    field_sel = i_min;
         default: field_sel = i_sec;
      endcase
      blank = i_set && phase_q && field_sel;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         blink_q <= '0;
         phase_q <= 1'b0;
      end else begin
         blink_q <= blink_d;
         phase_q <= phase_d;
      end
   end
`else
   logic unused_set_inputs;
   localparam int unused_blink_div = BLINK_DIV;
   assign unused_set_inputs = ^{i_set, i_hour, i_min, i_sec};
   assign blank             = 1'b0;
`endif

   always_comb begin
      case (idx_q[2:1])
         2'd0:    field_val = snap_h_q;
         2'd1:    field_val = snap_m_q;
         default: field_val = snap_s_q;
      endcase
      bcd   = to_bcd(field_val);
      digit = idx_q[0] ? bcd[3:0] : bcd[7:4];
      // dp separates hh.mm.ss and is never blanked.
      seg_d = {(idx_q == 3'd1) || (idx_q == 3'd3), blank ? 7'h00 : seg7(digit)};
      com_d = 6'b000001 << idx_q;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         scan_q   <= '0;
         idx_q    <= 3'd0;
         snap_h_q <= 6'd0;
         snap_m_q <= 6'd0;
         snap_s_q <= 6'd0;
         seg_q    <= 8'h00;
         com_q    <= 6'b000000;
      end else begin
         scan_q   <= scan_d;
         idx_q    <= idx_d;
         snap_h_q <= snap_h_d;
         snap_m_q <= snap_m_d;
         snap_s_q <= snap_s_d;
         seg_q    <= seg_d;
         com_q    <= com_d;
      end
   end

   assign o_seg = seg_q;
   assign o_com = com_q;

endmodule

// File: tb/tb_clock_display.sv
// Randomized and directed bench for clock_display against a cycle-position reference model.
module tb_clock_display;
   localparam int SD = 4;
   localparam int BD = 2;
   localparam int FR = 6 * SD;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] ch, cm, cs;
   logic       set, hr, mn, sc;
   logic [7:0] seg;
   logic [5:0] com;

   clock_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .i_clk(clk), .i_reset(rst_n),
      .i_count_h(ch), .i_count_m(cm), .i_count_s(cs),
      .i_set(set), .i_hour(hr), .i_min(mn), .i_sec(sc),
      .o_seg(seg), .o_com(com)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int e = 0;
   int mh = 0, mm = 0, ms = 0;
   int blanked = 0;
   logic [6:0] segtab [10];

   task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s e=%0d got=%h exp=%h", tag, e, got, exp);
      end
   endtask

   task automatic check_int(string tag, int got, int exp);
      checks++;
      assert (got == exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Output after edge e reflects position e-1 since release; the displayed
   // time is whatever was sampled at the end of the previous frame.
   task automatic step();
      logic [7:0] es;
      logic [5:0] ec;
      int p, idx, f, val, dig;
      @(posedge clk);
      e++;
      @(negedge clk);
      p   = e - 1;
      idx = (p / SD) % 6;
      f   = p / FR;
      val = (idx < 2) ? mh : (idx < 4) ? mm : ms;
      dig = (idx % 2 == 0) ? val / 10 : val % 10;
      es  = {(idx == 1 || idx == 3), segtab[dig]};
`ifdef DISPLAY_BLINK_EN
      if (set && ((f / BD) % 2 == 1) &&
          ((idx < 2 && hr) || (idx >= 2 && idx < 4 && mn) || (idx >= 4 && sc)))
         es[6:0] = 7'h00;
`endif
      ec = 6'(1 << idx);
      check("seg", seg, es);
      check("com", {2'b00, com}, {2'b00, ec});
      if (set && mn && (com[2] | com[3]) && seg[6:0] == 7'h00) blanked++;
      if (e % FR == 0) begin
         mh = ch; mm = cm; ms = cs;
      end
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      e = 0; mh = 0; mm = 0; ms = 0;
   endtask

   initial begin
      int e0, lat;
      bit found;
      segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      rst_n = 1'b0;
      ch = 0; cm = 0; cs = 0;
      set = 0; hr = 0; mn = 0; sc = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_seg", seg, 8'h00);
      check("rst_com", {2'b00, com}, 8'h00);
      release_reset();

      repeat (FR) step();

      ch = 23; cm = 59; cs = 7;
      repeat (2 * FR) step();

      ch = 12;
      repeat (FR) step();
      for (int i = 0; i < FR && (e % FR) != 9; i++) step();
      ch = 13; e0 = e; found = 0; lat = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (!found && com == 6'b000010 && seg == 8'hCF) begin
            found = 1; lat = e - e0;
         end
      end
      check_int("lat_seen", int'(found), 1);
      check_int("lat_bound", int'(lat <= 12 * SD + 1), 1);

      ch = 60; cm = 0; cs = 63;
      repeat (2 * FR) step();
      check_int("no_x", int'($isunknown({seg, com})), 0);

      blanked = 0;
      set = 1; mn = 1;
      repeat (4 * FR) step();
`ifdef DISPLAY_BLINK_EN
      check_int("blank_seen", int'(blanked > 0), 1);
`else
      check_int("no_blank", blanked, 0);
`endif
      set = 0; mn = 0;

      repeat (240) begin
         if ($urandom_range(15) == 0) ch = 6'($urandom_range(63));
         if ($urandom_range(15) == 0) cm = 6'($urandom_range(63));
         if ($urandom_range(7) == 0)  cs = 6'($urandom_range(63));
         if ($urandom_range(7) == 0) begin
            set = 1'($urandom_range(1));
            hr  = 1'($urandom_range(1));
            mn  = 1'($urandom_range(1));
            sc  = 1'($urandom_range(1));
         end
         step();
      end
      set = 0; hr = 0; mn = 0; sc = 0;

      for (int i = 0; i < FR && (e % FR) != 17; i++) step();
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_seg", seg, 8'h00);
      check("mid_rst_com", {2'b00, com}, 8'h00);
      release_reset();
      ch = 5; cm = 42; cs = 19;
      repeat (2 * FR) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
